// File: rtl/hls_txn_profiler.sv
// In-fabric profiler for ap_ctrl_hs handshakes: per-channel latency, initiation interval
// and stall statistics with an outstanding-start timestamp FIFO, read via a registered select port.
module hls_txn_profiler #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TS_DEPTH = 4,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] err
);
    localparam int unsigned PTR_W  = $clog2(TS_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0]  fifo_q     [NUM_CH][TS_DEPTH];
    logic [CNT_W-1:0]  fifo_d     [NUM_CH][TS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q   [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d   [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q   [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d   [NUM_CH];
    logic [FCNT_W-1:0] fcnt_q     [NUM_CH];
    logic [FCNT_W-1:0] fcnt_d     [NUM_CH];
    logic [CNT_W-1:0]  txn_q      [NUM_CH];
    logic [CNT_W-1:0]  txn_d      [NUM_CH];
    logic [CNT_W-1:0]  lat_sum_q  [NUM_CH];
    logic [CNT_W-1:0]  lat_sum_d  [NUM_CH];
    logic [CNT_W-1:0]  lat_min_q  [NUM_CH];
    logic [CNT_W-1:0]  lat_min_d  [NUM_CH];
    logic [CNT_W-1:0]  lat_max_q  [NUM_CH];
    logic [CNT_W-1:0]  lat_max_d  [NUM_CH];
    logic [CNT_W-1:0]  last_int_q [NUM_CH];
    logic [CNT_W-1:0]  last_int_d [NUM_CH];
    logic [CNT_W-1:0]  prev_ts_q  [NUM_CH];
    logic [CNT_W-1:0]  prev_ts_d  [NUM_CH];
    logic [CNT_W-1:0]  stall_q    [NUM_CH];
    logic [CNT_W-1:0]  stall_d    [NUM_CH];
    logic [CNT_W-1:0]  wait_cyc_q [NUM_CH];
    logic [CNT_W-1:0]  wait_cyc_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] has_prev_q, has_prev_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;

    logic [NUM_CH-1:0] start_evt, done_evt, empty, full, push, pop, upd_lat, ovf, unf;
    logic [CNT_W-1:0]  lat     [NUM_CH];
    logic [CNT_W:0]    sum_ext [NUM_CH];

    // Per-channel events; an empty-FIFO start+done pair bypasses the FIFO with zero latency
    always_comb begin
        start_evt = ap_start & ~pend_q;
        done_evt  = ap_done & ap_continue;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c]   = (fcnt_q[c] == '0);
            full[c]    = (fcnt_q[c] == FCNT_W'(TS_DEPTH));
            lat[c]     = empty[c] ? '0 : ts_q - fifo_q[c][rd_ptr_q[c]];
            sum_ext[c] = {1'b0, lat_sum_q[c]} + {1'b0, lat[c]};
        end
        pop     = done_evt & ~empty;
        upd_lat = done_evt & (~empty | start_evt);
        ovf     = start_evt & full & ~done_evt;
        unf     = done_evt & empty & ~start_evt;
        push    = start_evt & ~(empty & done_evt) & ~ovf;
    end

    // Next-state for statistics, FIFOs and handshake tracking
    always_comb begin
        ts_d       = ts_q + CNT_W'(1);
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcnt_d     = fcnt_q;
        txn_d      = txn_q;
        lat_sum_d  = lat_sum_q;
        lat_min_d  = lat_min_q;
        lat_max_d  = lat_max_q;
        last_int_d = last_int_q;
        prev_ts_d  = prev_ts_q;
        stall_d    = stall_q;
        wait_cyc_d = wait_cyc_q;
        pend_d     = pend_q;
        has_prev_d = has_prev_q;
        err_d      = err_q;
        if (clear) begin
            pend_d     = '0;
            has_prev_d = '0;
            err_d      = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_d[c]   = '0;
                rd_ptr_d[c]   = '0;
                fcnt_d[c]     = '0;
                txn_d[c]      = '0;
                lat_sum_d[c]  = '0;
                lat_min_d[c]  = ONES;
                lat_max_d[c]  = '0;
                last_int_d[c] = '0;
                prev_ts_d[c]  = '0;
                stall_d[c]    = '0;
                wait_cyc_d[c] = '0;
            end
        end else if (enable) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (upd_lat[c]) begin
                    lat_sum_d[c] = sum_ext[c][CNT_W] ? ONES : sum_ext[c][CNT_W-1:0];
                    if (lat[c] < lat_min_q[c]) lat_min_d[c] = lat[c];
                    if (lat[c] > lat_max_q[c]) lat_max_d[c] = lat[c];
                end
                if (done_evt[c]) txn_d[c] = txn_q[c] + CNT_W'(1);
                if (pop[c]) rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
                if (push[c]) begin
                    fifo_d[c][wr_ptr_q[c]] = ts_q;
                    wr_ptr_d[c]            = wr_ptr_q[c] + PTR_W'(1);
                end
                fcnt_d[c] = fcnt_q[c] + FCNT_W'(push[c]) - FCNT_W'(pop[c]);
                if (ovf[c] || unf[c]) err_d[c] = 1'b1;
                if (start_evt[c]) begin
                    if (has_prev_q[c]) last_int_d[c] = ts_q - prev_ts_q[c];
                    prev_ts_d[c]  = ts_q;
                    has_prev_d[c] = 1'b1;
                end
                if (ap_start[c] && ap_ready[c]) pend_d[c] = 1'b0;
                else if (start_evt[c])          pend_d[c] = 1'b1;
                if (ap_done[c] && !ap_continue[c] && stall_q[c] != ONES)
                    stall_d[c] = stall_q[c] + CNT_W'(1);
                if (pend_q[c] && !ap_ready[c] && wait_cyc_q[c] != ONES)
                    wait_cyc_d[c] = wait_cyc_q[c] + CNT_W'(1);
            end
        end
    end

    // Readout mux; out-of-range channels read as zero
    always_comb begin
        rd_data_d = '0;
        if (32'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                3'd0:    rd_data_d = txn_q[rd_ch];
                3'd1:    rd_data_d = lat_sum_q[rd_ch];
                3'd2:    rd_data_d = lat_min_q[rd_ch];
                3'd3:    rd_data_d = lat_max_q[rd_ch];
                3'd4:    rd_data_d = last_int_q[rd_ch];
                3'd5:    rd_data_d = stall_q[rd_ch];
                3'd6:    rd_data_d = wait_cyc_q[rd_ch];
                default: rd_data_d = CNT_W'({err_q[rd_ch], busy[rd_ch], fcnt_q[rd_ch]});
            endcase
        end
    end

    assign busy    = ~empty;
    assign err     = err_q;
    assign rd_data = rd_data_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ts_q       <= '0;
            pend_q     <= '0;
            has_prev_q <= '0;
            err_q      <= '0;
            rd_data_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < TS_DEPTH; i++) fifo_q[c][i] <= '0;
                wr_ptr_q[c]   <= '0;
                rd_ptr_q[c]   <= '0;
                fcnt_q[c]     <= '0;
                txn_q[c]      <= '0;
                lat_sum_q[c]  <= '0;
                lat_min_q[c]  <= ONES;
                lat_max_q[c]  <= '0;
                last_int_q[c] <= '0;
                prev_ts_q[c]  <= '0;
                stall_q[c]    <= '0;
                wait_cyc_q[c] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            txn_q      <= txn_d;
            lat_sum_q  <= lat_sum_d;
            lat_min_q  <= lat_min_d;
            lat_max_q  <= lat_max_d;
            last_int_q <= last_int_d;
            prev_ts_q  <= prev_ts_d;
            stall_q    <= stall_d;
            wait_cyc_q <= wait_cyc_d;
            pend_q     <= pend_d;
            has_prev_q <= has_prev_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_hls_txn_profiler.sv
// Scoreboard bench for hls_txn_profiler: directed handshake scenarios plus randomized traffic
// against a queue-based transaction model; a negedge monitor pops and compares expectations.
module tb_hls_txn_profiler;
    localparam int unsigned NC    = 5;
    localparam int unsigned CW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXV  = 255;

    logic          clk = 1'b0;
    logic          rst_n, en, clr;
    logic [NC-1:0] ap_start, ap_ready, ap_done, ap_cont;
    logic [2:0]    rd_ch, rd_sel;
    logic [CW-1:0] rd_data;
    logic [NC-1:0] busy, err;

    hls_txn_profiler #(.NUM_CH(NC), .CNT_W(CW), .TS_DEPTH(DEPTH)) dut (
        .clock(clk), .reset(rst_n), .enable(en), .clear(clr),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_cont),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned rq[$];
    logic [2*NC-1:0] bq[$];
    logic rd_req = 1'b0;
    logic rd_vld_q = 1'b0;
    int unsigned rd_exp_v = 0;

    // Transaction-level reference model
    int unsigned m_ts;
    int unsigned m_txn[NC], m_sum[NC], m_min[NC], m_max[NC], m_int[NC], m_prev[NC];
    int unsigned m_stall[NC], m_wait[NC];
    bit          m_pend[NC], m_hasp[NC], m_err[NC];
    int unsigned m_q[NC][$];

    function automatic int unsigned sat(int unsigned v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic void m_clear();
        for (int c = 0; c < NC; c++) begin
            m_txn[c] = 0; m_sum[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
            m_int[c] = 0; m_prev[c] = 0; m_stall[c] = 0; m_wait[c] = 0;
            m_pend[c] = 0; m_hasp[c] = 0; m_err[c] = 0;
            m_q[c].delete();
        end
    endfunction

    function automatic void m_step();
        int unsigned now, lat;
        bit s, d, emp;
        if (!rst_n) begin
            m_clear();
            m_ts = 0;
            return;
        end
        now  = m_ts;
        m_ts = (m_ts + 1) % 256;
        if (clr) begin
            m_clear();
            return;
        end
        if (!en) return;
        for (int c = 0; c < NC; c++) begin
            s   = ap_start[c] && !m_pend[c];
            d   = ap_done[c] && ap_cont[c];
            emp = (m_q[c].size() == 0);
            if (ap_done[c] && !ap_cont[c]) m_stall[c] = sat(m_stall[c] + 1);
            if (m_pend[c] && !ap_ready[c]) m_wait[c] = sat(m_wait[c] + 1);
            if (d) begin
                m_txn[c] = (m_txn[c] + 1) % 256;
                if (emp && !s) m_err[c] = 1;
                else begin
                    lat = emp ? 0 : (now + 256 - m_q[c].pop_front()) % 256;
                    m_sum[c] = sat(m_sum[c] + lat);
                    if (lat < m_min[c]) m_min[c] = lat;
                    if (lat > m_max[c]) m_max[c] = lat;
                end
            end
            if (s) begin
                if (m_hasp[c]) m_int[c] = (now + 256 - m_prev[c]) % 256;
                m_prev[c] = now;
                m_hasp[c] = 1;
                if (!(emp && d)) begin
                    if (m_q[c].size() < DEPTH) m_q[c].push_back(now);
                    else m_err[c] = 1;
                end
            end
            if (ap_start[c] && ap_ready[c]) m_pend[c] = 0;
            else if (s) m_pend[c] = 1;
        end
    endfunction

    function automatic int unsigned model_read(int ch, int sel);
        if (ch >= int'(NC)) return 0;
        case (sel)
            0: return m_txn[ch];
            1: return m_sum[ch];
            2: return m_min[ch];
            3: return m_max[ch];
            4: return m_int[ch];
            5: return m_stall[ch];
            6: return m_wait[ch];
            default: return (m_err[ch] ? 16 : 0) + (m_q[ch].size() != 0 ? 8 : 0) + m_q[ch].size();
        endcase
    endfunction

    function automatic logic [2*NC-1:0] m_flags();
        logic [2*NC-1:0] v;
        for (int c = 0; c < NC; c++) begin
            v[c]      = (m_q[c].size() != 0);
            v[NC + c] = m_err[c];
        end
        return v;
    endfunction

    // One clock: readout expectation from pre-edge state, flags from post-edge state
    task automatic tick();
        int unsigned rexp;
        bit rq_on;
        logic [2*NC-1:0] f;
        rq_on = rd_req;
        rexp  = rst_n ? rd_exp_v : 0;
        m_step();
        f = m_flags();
        @(posedge clk);
        if (rq_on) rq.push_back(rexp);
        bq.push_back(f);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic idle();
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_cont = '1;
    endtask

    task automatic req(int ch, int sel, int unsigned e);
        rd_ch = 3'(ch); rd_sel = 3'(sel); rd_exp_v = e; rd_req = 1'b1;
    endtask

    task automatic rdc(int ch, int sel, int unsigned e);
        idle();
        req(ch, sel, e);
        tick();
    endtask

    always @(posedge clk) rd_vld_q <= rd_req;

    always @(negedge clk) begin
        int unsigned e;
        logic [2*NC-1:0] fe;
        if (rd_vld_q) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rd_nodata: got=%0d with no expected entry", rd_data);
            end else begin
                e = rq.pop_front();
                if (rd_data !== CW'(e)) begin
                    bad++;
                    $display("FAIL rd_data t=%0t: got=%0d exp=%0d", $time, rd_data, e);
                end
            end
        end
        if (bq.size() != 0) begin
            fe = bq.pop_front();
            total++;
            if ({err, busy} !== fe) begin
                bad++;
                $display("FAIL err_busy t=%0t: got=%b exp=%b", $time, {err, busy}, fe);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_ch = 0; rd_sel = 0; en = 1'b1; clr = 1'b0; rst_n = 1'b0;
        idle();
        m_ts = 0;
        m_clear();
        tick(); tick();
        rst_n = 1'b1;
        rdc(0, 0, 0); rdc(0, 2, 255); rdc(0, 3, 0); rdc(4, 7, 0);

        // blocking txn on ch0: held start, ready+done 15 cycles later
        idle(); ap_start[0] = 1'b1;
        repeat (15) tick();
        ap_ready[0] = 1'b1; ap_done[0] = 1'b1;
        tick();
        rdc(0, 0, 1); rdc(0, 1, 15); rdc(0, 2, 15); rdc(0, 3, 15);
        rdc(0, 4, 0); rdc(0, 6, 14); rdc(0, 7, 0);

        // pipelined ch1: three overlapping transactions
        for (int k = 0; k < 22; k++) begin
            idle();
            if (k == 0 || k == 3 || k == 6) begin ap_start[1] = 1'b1; ap_ready[1] = 1'b1; end
            if (k == 15 || k == 18 || k == 21) ap_done[1] = 1'b1;
            if (k == 10) req(1, 7, 11);
            tick();
        end
        rdc(1, 0, 3); rdc(1, 1, 45); rdc(1, 2, 15); rdc(1, 3, 15); rdc(1, 4, 3); rdc(1, 7, 0);

        // overflow ch2
        idle(); ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
        repeat (5) tick();
        rdc(2, 7, 28);
        idle(); ap_done[2] = 1'b1;
        repeat (4) tick();
        rdc(2, 0, 4); rdc(2, 7, 16);

        // ch3 bypass, then a done stalled by ap_continue
        idle(); ap_start[3] = 1'b1; ap_ready[3] = 1'b1; ap_done[3] = 1'b1;
        tick();
        rdc(3, 0, 1); rdc(3, 2, 0); rdc(3, 7, 0);
        idle(); ap_start[3] = 1'b1; ap_ready[3] = 1'b1;
        tick();
        idle(); ap_done[3] = 1'b1; ap_cont[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req(3, 0, 1);
            tick();
        end
        idle(); ap_done[3] = 1'b1;
        tick();
        rdc(3, 0, 2); rdc(3, 5, 6); rdc(3, 3, 7);

        // enable=0 freezes, then clear
        idle(); ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        en = 1'b0; ap_done[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req(0, 0, 1);
            if (k == 4) req(0, 7, 9);
            tick();
        end
        en = 1'b1; idle(); ap_done[0] = 1'b1;
        tick();
        rdc(0, 0, 2); rdc(0, 7, 0);
        idle(); clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int s = 0; s < 8; s++) rdc(0, s, (s == 2) ? 255 : 0);
        rdc(5, 0, 0); rdc(7, 2, 0); rdc(2, 7, 0);

        // timestamp wrap: start at ts=250, done at ts=4
        idle();
        for (int k = 0; k < 300 && m_ts != 250; k++) tick();
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 300 && m_ts != 4; k++) tick();
        ap_done[1] = 1'b1;
        tick();
        rdc(1, 3, 10); rdc(1, 1, 10); rdc(1, 0, 1);

        // reset mid-flight, later done underflows
        idle(); ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
        tick();
        idle();
        repeat (3) tick();
        rst_n = 1'b0; req(2, 2, 0);
        tick();
        rst_n = 1'b1;
        rdc(2, 2, 255); rdc(2, 7, 0);
        idle(); ap_done[2] = 1'b1;
        tick();
        rdc(2, 0, 1); rdc(2, 7, 16);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NC; c++) begin
                ap_start[c] = ($urandom % 4) == 0;
                ap_ready[c] = ($urandom % 2) == 0;
                ap_done[c]  = ($urandom % 4) == 0;
                ap_cont[c]  = ($urandom % 4) != 0;
            end
            en    = ($urandom % 16) != 0;
            clr   = ($urandom % 128) == 0;
            rst_n = ($urandom % 700) != 0;
            rd_ch  = 3'($urandom % 8);
            rd_sel = 3'($urandom % 8);
            rd_exp_v = model_read(int'(rd_ch), int'(rd_sel));
            rd_req = 1'b1;
            tick();
        end
        rst_n = 1'b1; en = 1'b1; clr = 1'b0;
        idle();
        tick(); tick();

        @(negedge clk);
        @(negedge clk);
        total++;
        if (rq.size() != 0 || bq.size() != 0) begin
            bad++;
            $display("FAIL drain: rq=%0d bq=%0d left, want 0 0", rq.size(), bq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hls_txn_profiler.md
Name: hls_txn_profiler

Overview:
- Synthesizable, parametrised successor to the cosim-only dataflow/module status monitor.
- Observes NUM_CH ap_ctrl_hs handshakes (ap_start/ap_ready/ap_done/ap_continue) of HLS sub-blocks or pipelined loops, in-fabric.
- Accumulates per-channel transaction latency, initiation interval and stall statistics, and supports overlapping (pipelined) transactions.
- Sits beside the top-level HLS instance; results are read through a registered select port instead of CSV dumps.

Parameters:
NUM_CH, 4, number of monitored handshake channels (1..16)
CNT_W, 32, width of timestamp, counters and rd_data
TS_DEPTH, 4, per-channel outstanding-start timestamp FIFO depth (power of 2, >=2)

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = statistics and FIFOs update; 0 = frozen (timestamp keeps running)
clear  in  1  synchronous clear of stats, FIFOs and err; priority over enable
ap_start  in  NUM_CH  per-channel observed ap_start
ap_ready  in  NUM_CH  per-channel observed ap_ready
ap_done  in  NUM_CH  per-channel observed ap_done
ap_continue  in  NUM_CH  per-channel observed ap_continue (tie 1 if unused)
rd_ch  in  $clog2(NUM_CH) (min 1)  channel select for readout
rd_sel  in  3  statistic select
rd_data  out  CNT_W  registered readout
busy  out  NUM_CH  FIFO non-empty (transaction in flight)
err  out  NUM_CH  sticky overflow/underflow flag

Behaviour:
- Reset (reset==0 at posedge): timestamp=0, all counters 0, lat_min=all-ones, FIFOs empty, start_pending=0, rd_data=0, busy=0, err=0.
- Timestamp: free-running CNT_W counter, wraps; latency = (now - ts) mod 2^CNT_W, correct across one wrap.
- Per channel, one cycle:
  - start_evt = ap_start & ~start_pending.
  - start_pending set on start_evt & ~ap_ready; cleared on ap_start & ap_ready.
  - done_evt = ap_done & ap_continue.
- start_evt: push timestamp into FIFO.
  - If a previous start exists: last_interval = now - prev_start_ts; prev_start_ts = now.
- done_evt: pop head.
  - lat = now - head; txn_count+1; lat_sum += lat (saturating at all-ones); lat_min/lat_max updated.
- Simultaneous start_evt and done_evt:
  - FIFO empty: bypass, lat=0, FIFO stays empty.
  - FIFO full: pop+push legal, no overflow.
- Overflow: start_evt with FIFO full and no done_evt → timestamp dropped, err set.
- Underflow: done_evt with FIFO empty and no start_evt → txn_count+1 only, err set.
- Stall counters (saturating):
  - stall_cycles +1 when ap_done & ~ap_continue.
  - wait_cycles +1 when start_pending & ~ap_ready.
- enable=0: no pushes, pops, counter or pending updates; inputs ignored; timestamp runs.
- clear=1: as reset except timestamp and rd_data keep running.
- Readout, registered (rd_data valid 1 cycle after rd_ch/rd_sel):
  - 0 txn_count, 1 lat_sum, 2 lat_min, 3 lat_max, 4 last_interval, 5 stall_cycles, 6 wait_cycles.
  - 7 status: {.., err, busy, fifo_count}, zero-extended.
  - rd_ch >= NUM_CH returns 0.
- busy is combinational from FIFO count (registered state), no input-to-output path.
- Reset asserted mid-transaction: all state discarded; a later ap_done gives underflow + err.

Test Plan:
- Single blocking txn on ch0: start at t=10, ready+done at t=25 → txn_count=1, lat_min=lat_max=lat_sum=15, busy 1 for t 11..25, err=0.
- Pipelined ch1, starts accepted at t=5,8,11 (ready same cycle), dones at 20,23,26 → lat=15 each, last_interval=3, fifo_count peaks 3, err=0.
- Overflow ch2, TS_DEPTH=4: 5 starts, no done → fifo_count=4, err[2]=1; then 4 dones → txn_count=4, busy=0.
- Same-cycle start+ready+done on empty ch3 → lat=0, lat_min=0, busy stays 0; done with ap_continue=0 for 6 cycles → stall_cycles=6, txn counted only once continue=1.
- enable=0 during a txn window: counters frozen; clear=1 with enable=1 → rd_sel 2 reads all-ones, others 0; rd_ch=NUM_CH → rd_data 0.
- Timestamp wrap (CNT_W=8): start at ts=250, done at ts=4 → lat=10; reset low mid-flight → all outputs at reset values next cycle.
